cheri_tsmap_ctrl: RTL
=====================

# cheri_tsmap_ctrl

Temporal-safety revocation-map controller. It sits directly downstream of the CHERI core wrapper's TS-map port and owns the single-port map SRAM. It serves fixed-latency core lookups with absolute priority, arbitrates a host/revoker bus port into idle SRAM cycles, and provides a hardware bulk-clear engine. Core lookups never stall.

## Interface
- MapOffset, 16'h3800: word index of the map's first word in the core's tsmap address space ((TSMapBase − dRAM base) >> 2).
- MapWords, 2048: map depth in 32-bit words; power of two; AW = log2(MapWords).
- clk_i  in  1  clock; everything is rising-edge.
- rst_i  in  1  reset; synchronous, active-high.
- tsmap_cs_i  in  1  core lookup strobe.
- tsmap_addr_i  in  16  core word address (absolute, includes MapOffset).
- tsmap_rdata_o  out  32  lookup data; valid the cycle after tsmap_cs_i.
- tsmap_err_o  out  1  pulses with rdata when the lookup address was out of range.
- host_req_i  in  1  host request.
- host_gnt_o  out  1  host grant (combinational).
- host_we_i  in  1  write enable.
- host_be_i  in  4  byte enables.
- host_addr_i  in  32  byte address relative to map base.
- host_wdata_i  in  32  write data.
- host_rvalid_o  out  1  response strobe.
- host_rdata_o  out  32  read data; 0 for writes and errors.
- host_err_o  out  1  response error, qualified by host_rvalid_o.
- clear_start_i  in  1  bulk-clear start pulse.
- clear_busy_o  out  1  clear in progress.
- clear_done_o  out  1  one-cycle pulse when the clear completes.
- mem_cs_o  out  1  SRAM select.
- mem_we_o  out  1  SRAM write.
- mem_be_o  out  4  SRAM byte enables.
- mem_addr_o  out  AW  SRAM word address.
- mem_wdata_o  out  32  SRAM write data.
- mem_rdata_i  in  32  SRAM read data; 1-cycle latency.

## Operation
- States: IDLE, CLEAR. Reset puts the block in IDLE with the clear counter at 0.
- Core lookup, either state. Compute off = tsmap_addr_i − MapOffset as a 16-bit unsigned value. The lookup is in range iff off < MapWords.
  - IDLE, in range: mem_cs_o=1, we=0, addr=off[AW-1:0]. Next cycle tsmap_rdata_o = mem_rdata_i.
  - Out of range: no SRAM access. Next cycle rdata=32'hFFFF_FFFF and tsmap_err_o=1.
  - CLEAR: no SRAM access. Next cycle rdata=32'hFFFF_FFFF (conservative: treated as revoked) and err=0.
- A registered select (rsel: MEM / ONES) drives the rdata mux. When there is no lookup, rsel=MEM.
- Host arbitration: host_gnt_o = host_req_i & ~tsmap_cs_i & (state==IDLE) & ~clear_start_i.
- Host address decode:
  - In range iff host_addr_i[31:AW+2]==0. The word address is host_addr_i[AW+1:2].
  - Low address bits are ignored.
  - A granted in-range access drives the SRAM with we/be/wdata passed through.
  - A granted out-of-range access makes no SRAM access and responds with err=1.
- Host response: host_rvalid_o=1 exactly one cycle after the grant.
  - Reads: host_rdata_o = mem_rdata_i.
  - Writes and errors: host_rdata_o = 0.
- Bulk clear:
  - clear_start_i in IDLE moves the block to CLEAR with the counter at 0.
  - In CLEAR, every cycle writes 0 to counter address with be=4'hF, then increments the counter.
  - On the write at MapWords−1, the state returns to IDLE and clear_done_o pulses the following cycle.
  - clear_start_i is ignored while in CLEAR.
- Simultaneous events:
  - Core cs and host req in the same cycle: the core wins and the host waits (req held, no grant).
  - clear_start_i and host req in the same cycle: the clear wins.
  - A host grant is always single-cycle, so no host transaction is ever in flight when CLEAR begins.
- Reset mid-clear: the block returns to IDLE, busy=0, and no done pulse is issued. Map contents are undefined; software must re-run the clear.

## Timing
- Reset values:
  - host_gnt_o, host_rvalid_o, host_err_o, tsmap_err_o, clear_busy_o, clear_done_o, mem_cs_o, mem_we_o: 0.
  - host_rdata_o: 0. rsel: MEM.
- Core latency is exactly 1 cycle (cs at t, rdata/err at t+1). This matches the core's fixed-latency expectation. No backpressure.
- Host latency is grant at t, rvalid at t+1. Back-to-back grants are allowed every cycle.
- Clear duration: busy is high for MapWords cycles starting the cycle after the start. Done pulses the cycle after busy falls. At the default depth that is 2048 cycles.
- mem_* outputs are combinational from the arbitration inputs. Output paths are SRAM-to-rdata plus a 2:1 mux.

## Test plan
- Core lookup: preload word 5 = 32'hA5A5_0001 via host, then cs with addr 16'h3805 → next cycle rdata 32'hA5A5_0001, err 0.
- Out of range: core addr 16'h37FF, then 16'h4000 → rdata 32'hFFFF_FFFF with err=1 each time, and mem_cs_o stays 0.
- Contention: host write to byte address 0x10 held while core cs is asserted for 3 cycles → gnt only in the 4th cycle, rvalid in the 5th, and a later read of word 4 returns the written data.
- Host error: read at byte address 0x2000 → gnt, then rvalid with err=1 and rdata=0.
- Clear: fill words 0, 1023, 2047 with all-ones, then pulse clear_start_i → busy high for 2048 cycles and a done pulse. Core lookups during the clear return all-ones. Afterwards all three words read 0.
- Reset mid-clear: rst_i at clear cycle 100 → busy=0, no done pulse. A new start then completes in the full 2048 cycles.

Source files
------------

// File: rtl/cheri_tsmap_ctrl.sv
// cheri_tsmap_ctrl: temporal-safety revocation-map controller.
// Owns the single-port map SRAM. Core lookups have absolute priority and a
// fixed one-cycle latency. Host accesses fill idle SRAM cycles. A bulk-clear
// engine zeroes the whole map.
`timescale 1ns/1ps
module cheri_tsmap_ctrl #(
   parameter logic [15:0] MAP_OFFSET = 16'h3800,
   parameter int          MAP_WORDS  = 2048,
   parameter int          AW         = $clog2(MAP_WORDS),
   parameter int          DATA_W     = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // core TS-map lookup port
   input  logic              tsmap_cs_i,
   input  logic [15:0]       tsmap_addr_i,
   output logic [DATA_W-1:0] tsmap_rdata_o,
   output logic              tsmap_err_o,
   // host / revoker bus port
   input  logic              host_req_i,
   output logic              host_gnt_o,
   input  logic              host_we_i,
   input  logic [3:0]        host_be_i,
   input  logic [31:0]       host_addr_i,
   input  logic [DATA_W-1:0] host_wdata_i,
   output logic              host_rvalid_o,
   output logic [DATA_W-1:0] host_rdata_o,
   output logic              host_err_o,
   // bulk clear
   input  logic              clear_start_i,
   output logic              clear_busy_o,
   output logic              clear_done_o,
   // map SRAM
   output logic              mem_cs_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [AW-1:0]     mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic [16:0]   MAP_WORDS_W = 17'(MAP_WORDS);
   localparam logic [AW-1:0] LAST_WORD   = AW'(MAP_WORDS - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   logic [15:0] core_off;
   logic        core_in_range;
   logic        core_mem;
   logic        host_in_range;
   logic        host_mem;
   logic        last_clear;

   // Stage 1 registers: response selects and strobes for the cycle after issue
   logic        rsel_ones_p1;
   logic        tsmap_err_p1;
   logic        host_vld_p1;
   logic        host_err_p1;
   logic        host_rd_p1;
   logic        clear_done_p1;

   // host byte-offset bits carry no meaning for a word-wide map
   logic        unused_host_lsb;
   assign unused_host_lsb = ^host_addr_i[1:0];

   assign core_off      = tsmap_addr_i - MAP_OFFSET;
   assign core_in_range = ({1'b0, core_off} < MAP_WORDS_W);
   assign core_mem      = tsmap_cs_i & core_in_range & (state_q == IDLE);

   assign host_gnt_o    = host_req_i & ~tsmap_cs_i & (state_q == IDLE) & ~clear_start_i;
   assign host_in_range = (host_addr_i[31:AW+2] == '0);
   assign host_mem      = host_gnt_o & host_in_range;

   assign last_clear    = (state_q == CLEAR) && (cnt_q == LAST_WORD);

   // State and clear-counter register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic and SRAM port mux (clear > core > host)
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_cs_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (state_q)
         IDLE: begin
            if (clear_start_i) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
            if (core_mem) begin
               mem_cs_o   = 1'b1;
               mem_addr_o = core_off[AW-1:0];
            end else if (host_mem) begin
               mem_cs_o    = 1'b1;
               mem_we_o    = host_we_i;
               mem_be_o    = host_be_i;
               mem_addr_o  = host_addr_i[AW+1:2];
               mem_wdata_o = host_wdata_i;
            end
         end
         CLEAR: begin
            // one zero write per cycle; clear_start_i has no effect here
            mem_cs_o   = 1'b1;
            mem_we_o   = 1'b1;
            mem_be_o   = 4'hF;
            mem_addr_o = cnt_q;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Response pipeline: remember what each issued access must return next cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsel_ones_p1  <= 1'b0;
         tsmap_err_p1  <= 1'b0;
         host_vld_p1   <= 1'b0;
         host_err_p1   <= 1'b0;
         host_rd_p1    <= 1'b0;
         clear_done_p1 <= 1'b0;
      end else begin
         // during a clear every word is conservatively reported as revoked
         rsel_ones_p1  <= tsmap_cs_i & (~core_in_range | (state_q == CLEAR));
         tsmap_err_p1  <= tsmap_cs_i & ~core_in_range;
         host_vld_p1   <= host_gnt_o;
         host_err_p1   <= host_gnt_o & ~host_in_range;
         host_rd_p1    <= host_mem & ~host_we_i;
         clear_done_p1 <= last_clear;
      end
   end

   assign tsmap_rdata_o = rsel_ones_p1 ? {DATA_W{1'b1}} : mem_rdata_i;
   assign tsmap_err_o   = tsmap_err_p1;
   assign host_rvalid_o = host_vld_p1;
   assign host_err_o    = host_err_p1;
   assign host_rdata_o  = host_rd_p1 ? mem_rdata_i : '0;
   assign clear_busy_o  = (state_q == CLEAR);
   assign clear_done_o  = clear_done_p1;

endmodule
